mem_writeback: RTL and testbench

MEM_WRITEBACK -- requirements
Module: mem_writeback

---
 rtl/mem_writeback.sv | 139 +++++++++++++
 tb/tb_mem_writeback.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_writeback.sv
// MEM stage with MEM/WB pipeline register: issues data-memory requests, stalls the
// pipeline on multi-cycle accesses and latches an error on timeout or illegal control.
module mem_writeback #(
    parameter logic [7:0] MEM_TIMEOUT = 8'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ALUOut_EXMEM,
    input  logic [15:0] Rd2_EXMEM,
    input  logic [2:0]  WrR_EXMEM,
    input  logic        RegWrite_EXMEM,
    input  logic        MemtoReg_EXMEM,
    input  logic        MemRead_EXMEM,
    input  logic        MemWrite_EXMEM,
    input  logic        halt_EXMEM,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic        freeze,
    output logic [2:0]  WrR_MEMWB,
    output logic [15:0] writeData,
    output logic        RegWrite_MEMWB,
    output logic        MemtoReg_MEMWB,
    output logic        halt_MEMWB,
    output logic        err
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StErr  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  cnt_inc;
    logic        access;
    logic        illegal;
    logic        req_en;

    logic [2:0]  wrr_q, wrr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        regwrite_q, regwrite_d;
    logic        memtoreg_q, memtoreg_d;
    logic        halt_q, halt_d;

    assign access  = MemRead_EXMEM ^ MemWrite_EXMEM;
    assign illegal = MemRead_EXMEM & MemWrite_EXMEM;
    assign req_en  = access && (state_q == StIdle || state_q == StWait);

    assign mem_addr  = ALUOut_EXMEM;
    assign mem_wdata = Rd2_EXMEM;
    // Gated by rst so a reset mid-access drops the request without waiting for the state flop.
    assign mem_rd    = rst & req_en & MemRead_EXMEM;
    assign mem_wr    = rst & req_en & MemWrite_EXMEM;
    assign err       = (state_q == StErr);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        freeze  = 1'b0;
        cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        case (state_q)
            StIdle: begin
                if (illegal) begin
                    state_d = StErr;
                end else if (!access) begin
                    freeze = 1'b1;
                end else if (mem_done) begin
                    freeze = 1'b1;
                end else begin
                    state_d = StWait;
                    cnt_d   = 8'd0;
                end
            end
            StWait: begin
                if (mem_done) begin
                    freeze  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == MEM_TIMEOUT) begin
                        state_d = StErr;
                    end
                end
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        wrr_d      = wrr_q;
        wdata_d    = wdata_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        halt_d     = halt_q;
        if (freeze) begin
            wrr_d      = WrR_EXMEM;
            wdata_d    = MemtoReg_EXMEM ? mem_rdata : ALUOut_EXMEM;
            regwrite_d = RegWrite_EXMEM;
            memtoreg_d = MemtoReg_EXMEM;
            halt_d     = halt_EXMEM;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            wrr_q      <= 3'd0;
            wdata_q    <= 16'd0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wrr_q      <= wrr_d;
            wdata_q    <= wdata_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            halt_q     <= halt_d;
        end
    end

    assign WrR_MEMWB      = wrr_q;
    assign writeData      = wdata_q;
    assign RegWrite_MEMWB = regwrite_q;
    assign MemtoReg_MEMWB = memtoreg_q;
    assign halt_MEMWB     = halt_q;

endmodule

// File: tb/tb_mem_writeback.sv
// Directed bench for mem_writeback: ALU pass-through, load hit/stall, timeout, illegal, reset.
module tb_mem_writeback;

    logic        clk;
    logic        rst;
    logic [15:0] ALUOut_EXMEM;
    logic [15:0] Rd2_EXMEM;
    logic [2:0]  WrR_EXMEM;
    logic        RegWrite_EXMEM;
    logic        MemtoReg_EXMEM;
    logic        MemRead_EXMEM;
    logic        MemWrite_EXMEM;
    logic        halt_EXMEM;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        freeze;
    logic [2:0]  WrR_MEMWB;
    logic [15:0] writeData;
    logic        RegWrite_MEMWB;
    logic        MemtoReg_MEMWB;
    logic        halt_MEMWB;
    logic        err;

    int checks = 0;
    int errors = 0;

    mem_writeback #(.MEM_TIMEOUT(8'd64)) dut (
        .clk            (clk),
        .rst            (rst),
        .ALUOut_EXMEM   (ALUOut_EXMEM),
        .Rd2_EXMEM      (Rd2_EXMEM),
        .WrR_EXMEM      (WrR_EXMEM),
        .RegWrite_EXMEM (RegWrite_EXMEM),
        .MemtoReg_EXMEM (MemtoReg_EXMEM),
        .MemRead_EXMEM  (MemRead_EXMEM),
        .MemWrite_EXMEM (MemWrite_EXMEM),
        .halt_EXMEM     (halt_EXMEM),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .mem_rdata      (mem_rdata),
        .mem_done       (mem_done),
        .freeze         (freeze),
        .WrR_MEMWB      (WrR_MEMWB),
        .writeData      (writeData),
        .RegWrite_MEMWB (RegWrite_MEMWB),
        .MemtoReg_MEMWB (MemtoReg_MEMWB),
        .halt_MEMWB     (halt_MEMWB),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one EX/MEM bundle; memory-side inputs are driven separately.
    task automatic drive(input logic [15:0] alu, input logic [15:0] rd2, input logic [2:0] wrr,
                         input logic rw, input logic m2r, input logic mr, input logic mw,
                         input logic hlt);
        ALUOut_EXMEM   = alu;
        Rd2_EXMEM      = rd2;
        WrR_EXMEM      = wrr;
        RegWrite_EXMEM = rw;
        MemtoReg_EXMEM = m2r;
        MemRead_EXMEM  = mr;
        MemWrite_EXMEM = mw;
        halt_EXMEM     = hlt;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        drive(16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mem_rdata = 16'h0000;
        mem_done  = 1'b0;
        #12;
        checks++;
        if ({WrR_MEMWB, writeData, RegWrite_MEMWB, MemtoReg_MEMWB, halt_MEMWB, err} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs got wrr=%0d wd=%h rw=%b m2r=%b h=%b err=%b exp all 0",
                     WrR_MEMWB, writeData, RegWrite_MEMWB, MemtoReg_MEMWB, halt_MEMWB, err);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (freeze !== 1'b1) begin
            errors++;
            $display("FAIL reset_freeze got %b exp 1", freeze);
        end
        tick();
    endtask

    task automatic test_alu_op;
        drive(16'h1234, 16'h0000, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if ({freeze, mem_rd, mem_wr} !== 3'b100) begin
            errors++;
            $display("FAIL alu_ctrl got frz/rd/wr=%b%b%b exp 100", freeze, mem_rd, mem_wr);
        end
        checks++;
        if (mem_addr !== 16'h1234) begin
            errors++;
            $display("FAIL alu_addr got %h exp 1234", mem_addr);
        end
        tick();
        checks++;
        if (WrR_MEMWB !== 3'd3 || writeData !== 16'h1234 || RegWrite_MEMWB !== 1'b1) begin
            errors++;
            $display("FAIL alu_memwb got wrr=%0d wd=%h rw=%b exp 3 1234 1",
                     WrR_MEMWB, writeData, RegWrite_MEMWB);
        end
    endtask

    task automatic test_load_hit;
        drive(16'h0040, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        mem_rdata = 16'hBEEF;
        mem_done  = 1'b1;
        #1;
        checks++;
        if (freeze !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== 16'h0040) begin
            errors++;
            $display("FAIL hit_req got frz=%b rd=%b addr=%h exp 1 1 0040", freeze, mem_rd, mem_addr);
        end
        tick();
        mem_done = 1'b0;
        checks++;
        if (writeData !== 16'hBEEF || WrR_MEMWB !== 3'd2 || MemtoReg_MEMWB !== 1'b1) begin
            errors++;
            $display("FAIL hit_memwb got wd=%h wrr=%0d m2r=%b exp BEEF 2 1",
                     writeData, WrR_MEMWB, MemtoReg_MEMWB);
        end
    endtask

    task automatic test_load_stall;
        drive(16'h0080, 16'h0000, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        mem_rdata = 16'h0000;
        mem_done  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (freeze !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'h0080) begin
                errors++;
                $display("FAIL stall_cyc%0d got frz=%b rd=%b addr=%h exp 0 1 0080",
                         i, freeze, mem_rd, mem_addr);
            end
            tick();
            checks++;
            if (writeData !== 16'hBEEF || WrR_MEMWB !== 3'd2 || halt_MEMWB !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d got wd=%h wrr=%0d h=%b exp BEEF 2 0",
                         i, writeData, WrR_MEMWB, halt_MEMWB);
            end
        end
        mem_rdata = 16'hCAFE;
        mem_done  = 1'b1;
        #1;
        checks++;
        if (freeze !== 1'b1) begin
            errors++;
            $display("FAIL stall_done_freeze got %b exp 1", freeze);
        end
        tick();
        mem_done = 1'b0;
        checks++;
        if (writeData !== 16'hCAFE || WrR_MEMWB !== 3'd5 || halt_MEMWB !== 1'b1) begin
            errors++;
            $display("FAIL stall_load got wd=%h wrr=%0d h=%b exp CAFE 5 1",
                     writeData, WrR_MEMWB, halt_MEMWB);
        end
    endtask

    task automatic test_back_to_back;
        drive(16'hA001, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (writeData !== 16'hA001 || WrR_MEMWB !== 3'd1 || MemtoReg_MEMWB !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first got wd=%h wrr=%0d m2r=%b exp A001 1 0",
                     writeData, WrR_MEMWB, MemtoReg_MEMWB);
        end
        // MemtoReg=0 must select ALUOut even with junk on mem_rdata.
        mem_rdata = 16'hDEAD;
        drive(16'hB002, 16'h0000, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (writeData !== 16'hB002 || WrR_MEMWB !== 3'd6 || RegWrite_MEMWB !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second got wd=%h wrr=%0d rw=%b exp B002 6 0",
                     writeData, WrR_MEMWB, RegWrite_MEMWB);
        end
    endtask

    task automatic test_timeout;
        drive(16'h0100, 16'h5A5A, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        mem_done = 1'b0;
        #1;
        checks++;
        if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_wdata !== 16'h5A5A || freeze !== 1'b0) begin
            errors++;
            $display("FAIL store_req got wr=%b rd=%b wdata=%h frz=%b exp 1 0 5A5A 0",
                     mem_wr, mem_rd, mem_wdata, freeze);
        end
        // Issue edge plus 63 WAIT edges: still waiting.
        repeat (64) tick();
        checks++;
        if (err !== 1'b0 || mem_wr !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early got err=%b wr=%b exp 0 1", err, mem_wr);
        end
        tick();
        checks++;
        if (err !== 1'b1 || freeze !== 1'b0 || mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err got err=%b frz=%b wr=%b exp 1 0 0", err, freeze, mem_wr);
        end
        mem_done = 1'b1;
        drive(16'h7777, 16'h0000, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        mem_done = 1'b0;
        checks++;
        if (err !== 1'b1 || freeze !== 1'b0 || writeData !== 16'hB002) begin
            errors++;
            $display("FAIL err_sticky got err=%b frz=%b wd=%h exp 1 0 B002", err, freeze, writeData);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got %b exp 0", err);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_illegal;
        drive(16'h0200, 16'h1111, 3'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        checks++;
        if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL illegal_req got rd=%b wr=%b exp 0 0", mem_rd, mem_wr);
        end
        tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_err got %b exp 1", err);
        end
        rst = 1'b0;
        #1;
        rst = 1'b1;
        drive(16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid_wait;
        drive(16'h3C3C, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(16'h0300, 16'h0000, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        mem_done = 1'b0;
        repeat (2) tick();
        checks++;
        if (mem_rd !== 1'b1 || writeData !== 16'h3C3C || halt_MEMWB !== 1'b1) begin
            errors++;
            $display("FAIL prewait got rd=%b wd=%h h=%b exp 1 3C3C 1", mem_rd, writeData, halt_MEMWB);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (mem_rd !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_rd got %b exp 0", mem_rd);
        end
        checks++;
        if ({WrR_MEMWB, writeData, RegWrite_MEMWB, MemtoReg_MEMWB, halt_MEMWB} !== 22'd0) begin
            errors++;
            $display("FAIL rst_mid_memwb got wrr=%0d wd=%h rw=%b m2r=%b h=%b exp all 0",
                     WrR_MEMWB, writeData, RegWrite_MEMWB, MemtoReg_MEMWB, halt_MEMWB);
        end
        drive(16'h4242, 16'h0000, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (freeze !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL rst_release got frz=%b err=%b exp 1 0", freeze, err);
        end
        tick();
        checks++;
        if (writeData !== 16'h4242 || WrR_MEMWB !== 3'd6) begin
            errors++;
            $display("FAIL first_edge got wd=%h wrr=%0d exp 4242 6", writeData, WrR_MEMWB);
        end
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load_hit();
        test_load_stall();
        test_back_to_back();
        test_timeout();
        test_illegal();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
